pvr_plane_interp_mc: RTL and testbench
======================================

Name: pvr_plane_interp_mc

Overview:
- Multi-channel, pipelined successor to the PVR single-channel plane-equation interpolator.
- Per triangle, computes ddx/ddy/c for NUM_CH attributes (Z, U, V, colours…) that share one vertex X/Y set, using one shared sequential divider.
- Then evaluates x*ddx + y*ddy + c for a stream of integer pixel coordinates, with valid/ready handshakes on both sides.
- Sits between the triangle setup/edge walker and the ISP/TSP pixel pipe.

Parameters:
- NUM_CH, 4: attribute channels per triangle.
- DATA_W, 32: signed fixed-point width of vertex inputs and outputs.
- FRAC_BITS, 16: fractional bits of all fixed-point values.
- COORD_W, 11: unsigned pixel coordinate width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- setup_valid  in  1  triangle coefficients presented.
- setup_ready  out  1  setup can be accepted.
- fx1,fx2,fx3,fy1,fy2,fy3  in  DATA_W each  vertex X/Y, signed fixed point.
- fz1,fz2,fz3  in  NUM_CH*DATA_W each  per-channel vertex attribute; channel k in bits [k*DATA_W +: DATA_W].
- setup_done  out  1  one-cycle pulse when coefficients are valid.
- degenerate  out  1  last setup had C==0; held until next setup.
- pix_valid  in  1  pixel request.
- pix_ready  out  1  pixel accepted this cycle.
- pix_x, pix_y  in  COORD_W each  unsigned integer pixel coordinate.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_CH*DATA_W  interpolated attributes.
- out_x, out_y  out  COORD_W each  coordinates carried with the result.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all coefficient registers and outputs 0.
  - setup_ready=1, pix_ready=0, out_valid=0, setup_done=0, degenerate=0.
  - Reset mid-setup abandons the setup; setup_done does not pulse.
- FSM states: IDLE, DELTA, PRODS, DIV_X, DIV_Y, CONST, READY.
  - IDLE/READY → DELTA on setup_valid && setup_ready; all inputs are latched.
  - DELTA: register dx2=FX2-FX1, dx3=FX3-FX1, dy2=FY2-FY1, dy3=FY3-FY1 (DATA_W wrap), and C = (dx3*dy2 >>> F) - (dx2*dy3 >>> F), 2*DATA_W wide, sign pre-negated.
  - PRODS (per channel k): dz2, dz3; Aa = (dz3*dy2>>>F)-(dz2*dy3>>>F); Ba = (dx3*dz2>>>F)-(dx2*dz3>>>F).
  - DIV_X: ddx = (Aa<<<F)/C. DIV_Y: ddy = (Ba<<<F)/C. Each division takes DIV_LAT = 2*DATA_W+1 cycles.
  - CONST: c = fz1_k - (ddx*FX1>>>F) - (ddy*FY1>>>F). Then k++; if k<NUM_CH go to PRODS, else READY with setup_done=1 for one cycle.
  - Setup latency: setup_done occurs exactly 1 + NUM_CH*(2 + 2*DIV_LAT) cycles after the accept edge.
- Arithmetic:
  - Products are full 2*DATA_W; shifts are arithmetic.
  - Divide is signed, truncates toward zero; quotient is 2*DATA_W.
  - ddx, ddy, c are stored 2*DATA_W.
- C==0: divider bypassed (still DIV_LAT cycles); ddx=ddy=0, c=fz1_k; degenerate=1.
- setup_ready = IDLE || (READY && pipeline empty && !out_valid). New setup fully replaces coefficients; pix_ready=0 outside READY.
- Pixel pipe (READY only), 2 stages:
  - S1 registers x*ddx and y*ddy per channel, with x,y zero-extended.
  - S2 registers the sum + c, reduced to DATA_W.
  - Latency pix accept → out_valid = 2 cycles.
  - Pipe advances when !out_valid || out_ready; pix_ready = READY && advance.
  - Full throughput 1 pixel/cycle; order is preserved; no drop or duplicate under any out_ready pattern.
  - out_data/out_x/out_y hold stable while out_valid && !out_ready.
- Output reduction without the option: low DATA_W bits (wrap).

Optional Feature:
- PVR_INTERP_SAT_EN:
  - Defined: each channel's 2*DATA_W sum saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Undefined: truncation to the low DATA_W bits.
  - Latency unchanged either way.

Decomposition:
- Package pvr_interp_pkg:
  - FSM state enum.
  - DIV_LAT as a function of DATA_W.
  - Helper function sat_to_w for the saturation option.
- Sub-module pvr_seq_div: signed restoring divider, 1 quotient bit/cycle, with start/busy/done, zero-divisor flag and async active-high reset, instantiated once and shared across channels.

Test Plan:
1. NUM_CH=1, F=16. X=(0,0x100000,0), Y=(0,0,0x100000), Z=(0,0x100000,0) → ddx=0x10000, ddy=0, c=0; pixel (5,7) → out_data=0x50000 two cycles after accept; setup_done at the exact latency.
2. Same triangle, NUM_CH=4, Z ch1 = Y-plane (0,0,0x100000), ch2 constant 0x30000 → pixel (5,7) gives ch0=0x50000, ch1=0x70000, ch2=0x30000.
3. Collinear X=(0,0x10000,0x20000), Y=(0,0x10000,0x20000), Z1=0x1234 → degenerate=1; every pixel returns 0x1234 on every channel.
4. Stream 8 pixels back-to-back, out_ready low for cycles 3–5 → pix_ready drops; all 8 results emerge in order, held stable during stall.
5. Z=(0,0x7FFF0000,0) plane, pixel (2047,0) → 0x7FFFFFFF with PVR_INTERP_SAT_EN; wrapped low 32 bits without.
6. Reset asserted mid-DIV_X → outputs at reset values immediately; setup_done never pulses; a new setup afterwards completes normally.

Source files
------------

// File: rtl/pvr_interp_pkg.sv
// Shared types and helpers for the multi-channel plane-equation interpolator.
// sat_to_w is used only when PVR_INTERP_SAT_EN is defined.
package pvr_interp_pkg;

   typedef enum logic [2:0] {IDLE, DELTA, PRODS, DIV_X, DIV_Y, CONST, READY} state_t;

   localparam int SAT_MAX_W = 64;

   // One quotient bit per cycle plus the operand-load cycle.
   function automatic int div_lat(input int data_w);
      return 2 * data_w + 1;
   endfunction

   // Clamp a sign-extended value into the signed range of a w-bit result.
   function automatic logic signed [SAT_MAX_W-1:0] sat_to_w(
      input logic signed [2*SAT_MAX_W-1:0] v,
      input int                            w
   );
      logic signed [2*SAT_MAX_W-1:0] hi, lo;
      hi = {1'b0, {(2*SAT_MAX_W-1){1'b1}}} >> (2*SAT_MAX_W - w);
      lo = ~hi;
      if (v > hi)      return hi[SAT_MAX_W-1:0];
      else if (v < lo) return lo[SAT_MAX_W-1:0];
      else             return v[SAT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/pvr_seq_div.sv
// Signed restoring divider, one quotient bit per cycle, truncating toward zero.
// Operands load on start; quotient and done appear W cycles later.
module pvr_seq_div #(
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic         dz
);
   localparam int NW = $clog2(W + 1);

   logic [W-1:0]  rem, quo, dvs, rem_n, quo_n;
   logic [W:0]    rem_sh;
   logic          neg, ge;
   logic [NW-1:0] cnt;

   assign rem_sh = {rem, quo[W-1]};
   assign ge     = rem_sh >= {1'b0, dvs};
   assign rem_n  = ge ? W'(rem_sh - {1'b0, dvs}) : W'(rem_sh);
   assign quo_n  = {quo[W-2:0], ge};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rem <= '0; quo <= '0; dvs <= '0; neg <= 1'b0; cnt <= '0;
         busy <= 1'b0; done <= 1'b0; quotient <= '0; dz <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            // Magnitudes as unsigned; the sign is reapplied on the final step.
            quo  <= dividend[W-1] ? -dividend : dividend;
            dvs  <= divisor[W-1] ? -divisor : divisor;
            neg  <= dividend[W-1] ^ divisor[W-1];
            dz   <= (divisor == '0);
            rem  <= '0;
            cnt  <= NW'(W);
            busy <= 1'b1;
         end else if (busy) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt - 1'b1;
            if (cnt == NW'(1)) begin
               busy     <= 1'b0;
               done     <= 1'b1;
               quotient <= neg ? -quo_n : quo_n;
            end
         end
      end
   end

endmodule

// File: rtl/pvr_plane_interp_mc.sv
// Multi-channel plane-equation setup plus 2-stage pixel evaluator.
// Define PVR_INTERP_SAT_EN to saturate outputs instead of wrapping.
module pvr_plane_interp_mc
   import pvr_interp_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 32,
   parameter int FRAC_BITS = 16,
   parameter int COORD_W   = 11
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     setup_valid,
   output logic                     setup_ready,
   input  logic [DATA_W-1:0]        fx1, fx2, fx3, fy1, fy2, fy3,
   input  logic [NUM_CH*DATA_W-1:0] fz1, fz2, fz3,
   output logic                     setup_done,
   output logic                     degenerate,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [COORD_W-1:0]       pix_x, pix_y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [COORD_W-1:0]       out_x, out_y
);
   localparam int W2     = 2 * DATA_W;
   localparam int DL     = div_lat(DATA_W);
   localparam int KW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CW     = $clog2(DL + 1);
   localparam int STAGES = 2;

   state_t                        state;
   logic [KW-1:0]                 k;
   logic [CW-1:0]                 cnt;
   logic signed [DATA_W-1:0]      fx1_l, fx2_l, fx3_l, fy1_l, fy2_l, fy3_l;
   logic [NUM_CH-1:0][DATA_W-1:0] fz1_l, fz2_l, fz3_l;
   logic signed [W2-1:0]          dx2, dx3, dy2, dy3, cdet, aa, ba;
   logic [NUM_CH-1:0][W2-1:0]     ddx, ddy, cc;

   logic signed [DATA_W-1:0] dx2_n, dx3_n, dy2_n, dy3_n, dz2_n, dz3_n;
   logic signed [W2-1:0]     cdet_n, aa_n, ba_n, dz2_e, dz3_e, z1_e;
   logic signed [W2-1:0]     fx1_e, fy1_e, ddx_k, quot, cc_n;

   logic          div_start, div_busy, div_done, div_dz;
   logic [W2-1:0] div_a, div_q;

   assign dx2_n = fx2_l - fx1_l;
   assign dx3_n = fx3_l - fx1_l;
   assign dy2_n = fy2_l - fy1_l;
   assign dy3_n = fy3_l - fy1_l;
   assign cdet_n = ((W2'(dx3_n) * W2'(dy2_n)) >>> FRAC_BITS)
                 - ((W2'(dx2_n) * W2'(dy3_n)) >>> FRAC_BITS);

   assign dz2_n = fz2_l[k] - fz1_l[k];
   assign dz3_n = fz3_l[k] - fz1_l[k];
   assign dz2_e = W2'(dz2_n);
   assign dz3_e = W2'(dz3_n);
   assign aa_n  = ((dz3_e * dy2) >>> FRAC_BITS) - ((dz2_e * dy3) >>> FRAC_BITS);
   assign ba_n  = ((dx3 * dz2_e) >>> FRAC_BITS) - ((dx2 * dz3_e) >>> FRAC_BITS);

   // Zero determinant: quotient forced to 0, so c collapses to fz1.
   assign quot  = div_dz ? '0 : $signed(div_q);
   assign ddx_k = $signed(ddx[k]);
   assign z1_e  = W2'($signed(fz1_l[k]));
   assign fx1_e = W2'(fx1_l);
   assign fy1_e = W2'(fy1_l);
   assign cc_n  = z1_e - ((ddx_k * fx1_e) >>> FRAC_BITS) - ((quot * fy1_e) >>> FRAC_BITS);

   assign div_start = (state == DIV_X || state == DIV_Y) && cnt == '0 && !div_busy;
   assign div_a     = ((state == DIV_Y) ? ba : aa) <<< FRAC_BITS;

   pvr_seq_div #(.W(W2)) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend (div_a),
      .divisor  (cdet),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q),
      .dz       (div_dz)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE; k <= '0; cnt <= '0;
         fx1_l <= '0; fx2_l <= '0; fx3_l <= '0; fy1_l <= '0; fy2_l <= '0; fy3_l <= '0;
         fz1_l <= '0; fz2_l <= '0; fz3_l <= '0;
         dx2 <= '0; dx3 <= '0; dy2 <= '0; dy3 <= '0; cdet <= '0; aa <= '0; ba <= '0;
         ddx <= '0; ddy <= '0; cc <= '0;
         setup_done <= 1'b0; degenerate <= 1'b0;
      end else begin
         setup_done <= 1'b0;
         case (state)
            IDLE, READY: if (setup_valid && setup_ready) begin
               fx1_l <= fx1; fx2_l <= fx2; fx3_l <= fx3;
               fy1_l <= fy1; fy2_l <= fy2; fy3_l <= fy3;
               fz1_l <= fz1; fz2_l <= fz2; fz3_l <= fz3;
               state <= DELTA;
            end
            DELTA: begin
               dx2 <= W2'(dx2_n); dx3 <= W2'(dx3_n);
               dy2 <= W2'(dy2_n); dy3 <= W2'(dy3_n);
               cdet <= cdet_n;
               k <= '0;
               state <= PRODS;
            end
            PRODS: begin
               aa <= aa_n; ba <= ba_n; cnt <= '0;
               state <= DIV_X;
            end
            DIV_X, DIV_Y: begin
               // The X quotient lands as DIV_Y starts its own division.
               if (state == DIV_Y && cnt == '0 && div_done) ddx[k] <= quot;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(DL - 1)) begin
                  cnt   <= '0;
                  state <= (state == DIV_X) ? DIV_Y : CONST;
               end
            end
            CONST: begin
               ddy[k] <= quot;
               cc[k]  <= cc_n;
               if (k == KW'(NUM_CH - 1)) begin
                  state      <= READY;
                  setup_done <= 1'b1;
                  degenerate <= (cdet == '0);
               end else begin
                  k     <= k + 1'b1;
                  state <= PRODS;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [STAGES:0]               vld_pipe;
   logic                          advance;
   logic [W2-1:0]                 xe, ye;
   logic [NUM_CH-1:0][W2-1:0]     px_c, py_c, s1_px, s1_py;
   logic [NUM_CH-1:0][DATA_W-1:0] red_c, out_q;
   logic [COORD_W-1:0]            s1_x, s1_y;

   assign advance     = !vld_pipe[STAGES] || out_ready;
   assign pix_ready   = (state == READY) && advance;
   assign vld_pipe[0] = pix_valid && pix_ready;
   assign setup_ready = (state == IDLE) ||
                        (state == READY && !vld_pipe[1] && !vld_pipe[STAGES]);
   assign xe = W2'(pix_x);
   assign ye = W2'(pix_y);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign px_c[g] = xe * ddx[g];
      assign py_c[g] = ye * ddy[g];
`ifdef PVR_INTERP_SAT_EN
      logic [W2-1:0]                   sum;
      logic signed [2*SAT_MAX_W-1:0]   sat_in;
      logic signed [SAT_MAX_W-1:0]     sat_out;
      assign sum      = s1_px[g] + s1_py[g] + cc[g];
      assign sat_in   = (2*SAT_MAX_W)'($signed(sum));
      assign sat_out  = sat_to_w(sat_in, DATA_W);
      assign red_c[g] = sat_out[DATA_W-1:0];
`else
      assign red_c[g] = DATA_W'(s1_px[g] + s1_py[g] + cc[g]);
`endif
   end

   // The whole pipe stalls together, so nothing can be dropped or duplicated.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_pipe[STAGES:1] <= '0;
         s1_px <= '0; s1_py <= '0; s1_x <= '0; s1_y <= '0;
         out_q <= '0; out_x <= '0; out_y <= '0;
      end else if (advance) begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         s1_px <= px_c; s1_py <= py_c; s1_x <= pix_x; s1_y <= pix_y;
         out_q <= red_c; out_x <= s1_x; out_y <= s1_y;
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign out_data  = out_q;

endmodule

// File: tb/tb_pvr_plane_interp_mc.sv
// Directed bench for pvr_plane_interp_mc (NUM_CH=4); expected values worked by hand.
module tb_pvr_plane_interp_mc;
   localparam int NUM_CH    = 4;
   localparam int DATA_W    = 32;
   localparam int FRAC_BITS = 16;
   localparam int COORD_W   = 11;
   localparam int DIV_LAT   = 2 * DATA_W + 1;
   localparam int SETUP_LAT = 1 + NUM_CH * (2 + 2 * DIV_LAT);
`ifdef PVR_INTERP_SAT_EN
   localparam logic [31:0] EXP_BIG = 32'h7FFFFFFF;
`else
   localparam logic [31:0] EXP_BIG = 32'hF7801000;
`endif

   logic                     clock = 1'b0, reset;
   logic                     setup_valid, setup_ready, setup_done, degenerate;
   logic [DATA_W-1:0]        fx1, fx2, fx3, fy1, fy2, fy3;
   logic [NUM_CH*DATA_W-1:0] fz1, fz2, fz3, out_data;
   logic                     pix_valid, pix_ready, out_valid, out_ready;
   logic [COORD_W-1:0]       pix_x, pix_y, out_x, out_y;

   int n_chk = 0, n_pass = 0;

   pvr_plane_interp_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS),
                         .COORD_W(COORD_W)) dut (
      .clock(clock), .reset(reset),
      .setup_valid(setup_valid), .setup_ready(setup_ready),
      .fx1(fx1), .fx2(fx2), .fx3(fx3), .fy1(fy1), .fy2(fy2), .fy3(fy3),
      .fz1(fz1), .fz2(fz2), .fz3(fz3),
      .setup_done(setup_done), .degenerate(degenerate),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_x(out_x), .out_y(out_y)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clock); #1;
   endtask

   task automatic do_setup(input logic [DATA_W-1:0] x1, x2, x3, y1, y2, y3,
                           input logic [NUM_CH*DATA_W-1:0] z1, z2, z3, input string tag);
      int w, lat;
      fx1 = x1; fx2 = x2; fx3 = x3; fy1 = y1; fy2 = y2; fy3 = y3;
      fz1 = z1; fz2 = z2; fz3 = z3;
      setup_valid = 1'b1;
      w = 0;
      while (!setup_ready && w < 50) begin tick; w++; end
      tick;
      setup_valid = 1'b0;
      lat = 0;
      while (!setup_done && lat < 2000) begin tick; lat++; end
      chk({tag, " latency"}, 128'(lat), 128'(SETUP_LAT));
      tick;
      chk({tag, " done pulse width"}, 128'(setup_done), 128'(0));
   endtask

   task automatic pix1(input logic [COORD_W-1:0] x, y,
                       input logic [NUM_CH*DATA_W-1:0] exp_d, input string tag);
      pix_valid = 1'b1; pix_x = x; pix_y = y; out_ready = 1'b1;
      #1;
      chk({tag, " pix_ready"}, 128'(pix_ready), 128'(1));
      tick;
      pix_valid = 1'b0;
      chk({tag, " not valid after 1"}, 128'(out_valid), 128'(0));
      tick;
      chk({tag, " out_valid"}, 128'(out_valid), 128'(1));
      for (int c = 0; c < NUM_CH; c++)
         chk($sformatf("%s ch%0d", tag, c), 128'(out_data[c*DATA_W +: DATA_W]),
             128'(exp_d[c*DATA_W +: DATA_W]));
      chk({tag, " xy"}, 128'({out_x, out_y}), 128'({x, y}));
      tick;
   endtask

   logic [NUM_CH*DATA_W-1:0] za1, za2, za3, exp_q [8];
   int  sent, recv;
   logic fire, saw_stall, no_done;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; setup_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
      fx1 = '0; fx2 = '0; fx3 = '0; fy1 = '0; fy2 = '0; fy3 = '0;
      fz1 = '0; fz2 = '0; fz3 = '0; pix_x = '0; pix_y = '0;
      repeat (3) tick;
      chk("rst setup_ready", 128'(setup_ready), 128'(1));
      chk("rst pix_ready",   128'(pix_ready),   128'(0));
      chk("rst out_valid",   128'(out_valid),   128'(0));
      chk("rst setup_done",  128'(setup_done),  128'(0));
      chk("rst degenerate",  128'(degenerate),  128'(0));
      chk("rst out_data",    128'(out_data),    128'(0));
      reset = 1'b0;
      tick;

      // ch0 X-plane, ch1 Y-plane, ch2 constant, ch3 steep X-plane
      za1 = {32'h0,        32'h30000, 32'h0,      32'h0};
      za2 = {32'h7FFF0000, 32'h30000, 32'h0,      32'h100000};
      za3 = {32'h0,        32'h30000, 32'h100000, 32'h0};
      do_setup(32'h0, 32'h100000, 32'h0, 32'h0, 32'h0, 32'h100000, za1, za2, za3, "setupA");
      chk("setupA degenerate", 128'(degenerate), 128'(0));
      chk("setupA setup_ready", 128'(setup_ready), 128'(1));
      pix1(11'd5, 11'd7, {32'h27FFB000, 32'h30000, 32'h70000, 32'h50000}, "pix5_7");
      pix1(11'd2047, 11'd0, {EXP_BIG, 32'h30000, 32'h0, 32'h07FF0000}, "pix2047_0");

      // Back-to-back stream with downstream stalled for cycles 3..5
      for (int i = 0; i < 8; i++)
         exp_q[i] = {32'((i + 1) * 32'h7FFF000), 32'h30000,
                     32'((2 * i) << 16), 32'((i + 1) << 16)};
      sent = 0; recv = 0; saw_stall = 1'b0;
      for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 5);
         pix_valid = (sent < 8);
         pix_x = COORD_W'(sent + 1);
         pix_y = COORD_W'(2 * sent);
         #1;
         if (out_valid) begin
            chk($sformatf("stream data %0d", recv), 128'(out_data), 128'(exp_q[recv]));
            if (out_ready) begin
               chk($sformatf("stream xy %0d", recv), 128'({out_x, out_y}),
                   128'({COORD_W'(recv + 1), COORD_W'(2 * recv)}));
               recv++;
            end
         end
         if (pix_valid && !pix_ready) saw_stall = 1'b1;
         fire = pix_valid && pix_ready;
         tick;
         if (fire) sent++;
      end
      pix_valid = 1'b0; out_ready = 1'b1;
      chk("stream count", 128'(recv), 128'(8));
      chk("stream pix_ready stall", 128'(saw_stall), 128'(1));
      tick;

      // Collinear vertices
      do_setup(32'h0, 32'h10000, 32'h20000, 32'h0, 32'h10000, 32'h20000,
               {4{32'h1234}}, {4{32'h5555}}, {4{32'h9999}}, "setupC");
      chk("setupC degenerate", 128'(degenerate), 128'(1));
      pix1(11'd5, 11'd7, {4{32'h1234}}, "degen5_7");
      pix1(11'd100, 11'd33, {4{32'h1234}}, "degen100_33");

      // Reset in the middle of the first X division
      fx1 = 32'h0; fx2 = 32'h100000; fx3 = 32'h0; fy1 = 32'h0; fy2 = 32'h0; fy3 = 32'h100000;
      fz1 = za1; fz2 = za2; fz3 = za3;
      setup_valid = 1'b1;
      #1;
      chk("midrst setup_ready", 128'(setup_ready), 128'(1));
      tick;
      setup_valid = 1'b0;
      repeat (12) tick;
      reset = 1'b1;
      #1;
      chk("midrst async setup_ready", 128'(setup_ready), 128'(1));
      chk("midrst async degenerate",  128'(degenerate),  128'(0));
      chk("midrst async out_data",    128'(out_data),    128'(0));
      chk("midrst async pix_ready",   128'(pix_ready),   128'(0));
      repeat (2) tick;
      reset = 1'b0;
      no_done = 1'b1;
      repeat (600) begin
         tick;
         if (setup_done) no_done = 1'b0;
      end
      chk("midrst no setup_done", 128'(no_done), 128'(1));
      do_setup(32'h0, 32'h100000, 32'h0, 32'h0, 32'h0, 32'h100000, za1, za2, za3, "setupR");
      chk("setupR degenerate", 128'(degenerate), 128'(0));
      pix1(11'd5, 11'd7, {32'h27FFB000, 32'h30000, 32'h70000, 32'h50000}, "post_rst5_7");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
